// File: rtl/disp_pkg.sv
// Shared constants and FSM state type for the multiplexed 4-digit display scanner.
package disp_pkg;
  localparam int NDIG = 4;
  localparam int NIB_W = 4;
  localparam logic [NDIG-1:0] AN_OFF = 4'b1111;

  typedef enum logic {BLANK, DRIVE} st_t;
endpackage

// File: rtl/disp_tick.sv
// Slot prescaler and digit index; flags the last cycle of each slot and of each frame.
module disp_tick
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic [1:0]    idx,
  output logic          wrap,
  output logic          bnd
);
  assign wrap = (cnt == CW'(SCAN_DIV - 1));
  assign bnd  = wrap && (idx == 2'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/disp_scan.sv
// Tear-free multiplexed hex display scanner with anti-ghost blanking per slot.
// Optional leading-zero blanking is enabled by defining DISP_SCAN_LZB_EN.
module disp_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  output logic [3:0]  dis,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        ack,
  output logic        frame
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          wrap, bnd;

  disp_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .cnt  (cnt),
    .idx  (idx),
    .wrap (wrap),
    .bnd  (bnd)
  );

  st_t                    st;
  logic                   pend;
  logic [NDIG*NIB_W-1:0]  pending, disp_reg;
  logic [NDIG-1:0]        pend_dp, disp_dp;
  logic [NDIG-1:0]        lz;

`ifdef DISP_SCAN_LZB_EN
  // Digit k is suppressed when it and every more-significant nibble are zero.
  assign lz[0] = 1'b0;
  for (genvar k = 1; k < NDIG; k++) begin : g_lz
    assign lz[k] = ~|disp_reg[NDIG*NIB_W-1:NIB_W*k];
  end
`else
  assign lz = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= BLANK;
      pend     <= 1'b0;
      pending  <= '0;
      pend_dp  <= '0;
      disp_reg <= '0;
      disp_dp  <= '0;
      an       <= AN_OFF;
      dis      <= '0;
      dp_n     <= 1'b1;
      ack      <= 1'b0;
      frame    <= 1'b0;
    end else begin
      if (wrap)                                st <= BLANK;
      else if (cnt == CW'(BLANK_CYC - 1))      st <= DRIVE;

      // Outputs are computed from this cycle's slot position and the old frame's data.
      an    <= (st == DRIVE && !lz[idx]) ? ~(4'b0001 << idx) : AN_OFF;
      dis   <= disp_reg[{idx, 2'b00} +: NIB_W];
      dp_n  <= (st == DRIVE) ? ~disp_dp[idx] : 1'b1;
      ack   <= bnd && (load || pend);
      frame <= bnd;

      // Display contents only change at a frame boundary; a load landing there bypasses pending.
      if (bnd) begin
        pend <= 1'b0;
        if (load) begin
          disp_reg <= value;
          disp_dp  <= dp;
        end else if (pend) begin
          disp_reg <= pending;
          disp_dp  <= pend_dp;
        end
      end else if (load) begin
        pend    <= 1'b1;
        pending <= value;
        pend_dp <= dp;
      end
    end
  end
endmodule

// File: tb/tb_disp_scan.sv
// Randomized bench for disp_scan with a time-indexed behavioural display model.
module tb_disp_scan;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  dis, an;
  logic        dp_n, ack, frame;

  int total = 0;
  int bad = 0;

  disp_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .value(value),
    .dp   (dp),
    .dis  (dis),
    .an   (an),
    .dp_n (dp_n),
    .ack  (ack),
    .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position in the frame is just elapsed cycles since reset modulo the frame length.
  int          m_t, c, i;
  logic        m_bnd, m_drive, m_pend;
  logic [15:0] m_pv, m_disp;
  logic [3:0]  m_pdp, m_ddp;
  logic [3:0]  e_an, e_dis;
  logic        e_dpn, e_ack, e_frame, e_drv;

  function automatic logic lzb(input logic [15:0] v, input int k);
`ifdef DISP_SCAN_LZB_EN
    return (k != 0) && ((v >> (4 * k)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  always_comb begin
    c = m_t % SD;
    i = (m_t / SD) % 4;
    m_bnd = (c == SD - 1) && (i == 3);
    m_drive = (c >= BC);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_pend <= 1'b0; m_pv <= '0; m_pdp <= '0; m_disp <= '0; m_ddp <= '0;
      e_an <= 4'hF; e_dis <= '0; e_dpn <= 1'b1; e_ack <= 1'b0; e_frame <= 1'b0; e_drv <= 1'b0;
    end else begin
      m_t     <= (m_t + 1) % FR;
      e_drv   <= m_drive && !lzb(m_disp, i);
      e_an    <= (m_drive && !lzb(m_disp, i)) ? 4'(~(4'b0001 << i)) : 4'hF;
      e_dis   <= 4'(m_disp >> (4 * i));
      e_dpn   <= m_drive ? ~m_ddp[i] : 1'b1;
      e_ack   <= m_bnd && (load || m_pend);
      e_frame <= m_bnd;
      if (m_bnd) begin
        m_pend <= 1'b0;
        if (load) begin m_disp <= value; m_ddp <= dp; end
        else if (m_pend) begin m_disp <= m_pv; m_ddp <= m_pdp; end
      end else if (load) begin
        m_pend <= 1'b1; m_pv <= value; m_pdp <= dp;
      end
    end
  end

  always @(negedge clk) begin
    chk("an", an, e_an);
    chk("dp_n", dp_n, e_dpn);
    chk("ack", ack, e_ack);
    chk("frame", frame, e_frame);
    if (e_drv) chk("dis", dis, e_dis);
  end

  task automatic wait_frame();
    for (int n = 0; n < 2 * FR; n++) begin
      @(negedge clk);
      if (frame === 1'b1) return;
    end
    chk("frame_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    #1 load = 1'b1; value = v; dp = d;
    @(negedge clk);
    #1 load = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nx, ny, found;
    #12;
    chk("rst_an", an, 4'hF);
    chk("rst_dis", dis, 4'h0);
    chk("rst_dpn", dp_n, 1'b1);
    chk("rst_ack", ack, 1'b0);
    chk("rst_frame", frame, 1'b0);
    @(negedge clk); #1 rst_n = 1'b1;

    // 1A3F loaded mid-frame; literal slot pattern of the frame after it is applied
    wait_frame();
    repeat (5) @(negedge clk);
    do_load(16'h1A3F, 4'h0);
    wait_frame();
    chk("ack_1a3f", ack, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1) chk("blank_an", an, 4'hF);
      if (k == 3) begin chk("d0_an", an, 4'hE); chk("d0_dis", dis, 4'hF); end
      if (k == 11) begin chk("d1_an", an, 4'hD); chk("d1_dis", dis, 4'h3); end
      if (k == 19) begin chk("d2_an", an, 4'hB); chk("d2_dis", dis, 4'hA); end
      if (k == 27) begin chk("d3_an", an, 4'h7); chk("d3_dis", dis, 4'h1); end
    end
    chk("pre_rst_an", an, 4'h7);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_dpn", dp_n, 1'b1);
    chk("arst_dis", dis, 4'h0);
    chk("arst_ack", ack, 1'b0);
    @(negedge clk); #1 rst_n = 1'b1;

    // two loads before one boundary
    wait_frame();
    repeat (4) @(negedge clk);
    #1 load = 1'b1; value = 16'h1111; dp = 4'h0;
    @(negedge clk); #1 value = 16'h2222;
    @(negedge clk); #1 load = 1'b0;
    na = 0;
    for (int n = 0; n < 40; n++) begin @(negedge clk); if (ack) na++; end
    chk("ack_count_2222", na, 1);
    wait_frame();
    nx = 0; ny = 0;
    for (int n = 0; n < FR; n++) begin
      @(negedge clk);
      if (an != 4'hF && dis == 4'h2) nx++;
      if (an != 4'hF && dis == 4'h1) ny++;
    end
    chk("drv_2222", nx, 24);
    chk("drv_1111", ny, 0);

    // load exactly on the boundary cycle
    found = 0;
    for (int n = 0; n < 2 * FR && found == 0; n++) begin
      @(negedge clk);
      if (m_bnd) found = 1;
    end
    chk("bnd_found", found, 1);
    do_load(16'h00C5, 4'h0);
    chk("bnd_frame", frame, 1'b1);
    chk("bnd_ack", ack, 1'b1);
    na = 0;
    for (int n = 0; n < 40; n++) begin @(negedge clk); if (ack) na++; end
    chk("bnd_extra_ack", na, 0);

    // decimal point on digit 2 only
    repeat (3) @(negedge clk);
    do_load(16'h1234, 4'b0100);
    wait_frame();
    nx = 0; ny = 0;
    for (int n = 0; n < FR; n++) begin
      @(negedge clk);
      if (!dp_n) nx++;
      if (!dp_n && an != 4'b1011) ny++;
    end
    chk("dp_cycles", nx, 6);
    chk("dp_wrong_digit", ny, 0);

    // leading-zero case
    do_load(16'h0040, 4'h0);
    wait_frame();
    nx = 0; ny = 0; na = 0;
    for (int n = 0; n < FR; n++) begin
      @(negedge clk);
      if (an != 4'hF) nx++;
      if (an == 4'hD && dis == 4'h4) ny++;
      if (an == 4'hE && dis == 4'h0) na++;
    end
`ifdef DISP_SCAN_LZB_EN
    chk("lzb_driven", nx, 12);
`else
    chk("lzb_driven", nx, 24);
`endif
    chk("lzb_d1", ny, 6);
    chk("lzb_d0", na, 6);

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      #1;
      load = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: value = 16'($urandom);
        1: value = 16'($urandom) & 16'h0FFF;
        2: value = 16'($urandom) & 16'h00FF;
        default: value = 16'($urandom) & 16'h000F;
      endcase
      dp = 4'($urandom);
      if (n == 700 || n == 1203) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    @(negedge clk); #1 load = 1'b0; rst_n = 1'b1;
    repeat (FR) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
